// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 machine-mode trap controller.
//   state_e     : controller state encoding
//   PC_SRC_*    : PC mux select codes
//   CAUSE_*     : mcause exception / interrupt codes
//   OPCODE_SYSTEM, FUNCT3_PRIV, FUNCT7_*, RS2_* : SYSTEM instruction decode fields
package msrv32_pkg;

  typedef enum logic [1:0] {
    ST_RESET       = 2'b00,
    ST_OPERATING   = 2'b01,
    ST_TRAP_TAKEN  = 2'b10,
    ST_TRAP_RETURN = 2'b11
  } state_e;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
  localparam logic [3:0] CAUSE_M_SW_INT         = 4'd3;
  localparam logic [3:0] CAUSE_M_TIMER_INT      = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT_INT        = 4'd11;

  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
  localparam logic [2:0] FUNCT3_PRIV   = 3'b000;
  localparam logic [6:0] FUNCT7_ZERO   = 7'b0000000;
  localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;
  localparam logic [4:0] RS2_ECALL     = 5'b00000;
  localparam logic [4:0] RS2_EBREAK    = 5'b00001;
  localparam logic [4:0] RS2_MRET      = 5'b00010;

endpackage

// File: rtl/msrv32_trap_cause_enc.sv
// Combinational trap priority encoder.
// Inputs : fault flags, SYSTEM instruction fields, MIE/mie/mip bits.
// Outputs: valid_o (any exception or enabled interrupt), i_or_e_o, cause_o,
//          mret_o (mret decoded, independent of trap conditions).
module msrv32_trap_cause_enc
  import msrv32_pkg::*;
(
  input  logic       illegal_instr_i,
  input  logic       misaligned_instr_i,
  input  logic       misaligned_load_i,
  input  logic       misaligned_store_i,
  input  logic [4:0] opcode_6_to_2_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic [4:0] rs2_addr_i,
  input  logic       mie_i,
  input  logic       meie_i,
  input  logic       mtie_i,
  input  logic       msie_i,
  input  logic       meip_i,
  input  logic       mtip_i,
  input  logic       msip_i,
  output logic       valid_o,
  output logic       i_or_e_o,
  output logic [3:0] cause_o,
  output logic       mret_o
);

  logic is_system;
  logic ecall, ebreak;
  logic ext_irq, sw_irq, tmr_irq, irq;

  assign is_system = (opcode_6_to_2_i == OPCODE_SYSTEM) && (funct3_i == FUNCT3_PRIV);
  assign ecall     = is_system && (rs2_addr_i == RS2_ECALL)  && (funct7_i == FUNCT7_ZERO);
  assign ebreak    = is_system && (rs2_addr_i == RS2_EBREAK) && (funct7_i == FUNCT7_ZERO);
  assign mret_o    = is_system && (rs2_addr_i == RS2_MRET)   && (funct7_i == FUNCT7_MRET);

  assign ext_irq = meie_i & meip_i;
  assign sw_irq  = msie_i & msip_i;
  assign tmr_irq = mtie_i & mtip_i;
  assign irq     = mie_i & (ext_irq | sw_irq | tmr_irq);

  always_comb begin
    valid_o  = 1'b1;
    i_or_e_o = 1'b0;
    cause_o  = '0;
    // Exceptions win over interrupts; within each group first match wins.
    if (misaligned_instr_i)      cause_o = CAUSE_INSTR_MISALIGNED;
    else if (illegal_instr_i)    cause_o = CAUSE_ILLEGAL_INSTR;
    else if (ebreak)             cause_o = CAUSE_BREAKPOINT;
    else if (misaligned_load_i)  cause_o = CAUSE_LOAD_MISALIGNED;
    else if (misaligned_store_i) cause_o = CAUSE_STORE_MISALIGNED;
    else if (ecall)              cause_o = CAUSE_ECALL_M;
    else if (irq) begin
      i_or_e_o = 1'b1;
      if (ext_irq)     cause_o = CAUSE_M_EXT_INT;
      else if (sw_irq) cause_o = CAUSE_M_SW_INT;
      else             cause_o = CAUSE_M_TIMER_INT;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap/return controller: sequences reset, normal issue,
// trap entry and mret for the msrv32 core.
// Inputs : clk_in, reset_n_in (async, active low), fault flags, instr fields,
//          mstatus.MIE, mie.{MEIE,MTIE,MSIE}, mip.{MEIP,MTIP,MSIP}.
// Outputs: pc_src_out, flush_out, trap_taken_out, set_epc_out, set_cause_out,
//          i_or_e_out, cause_out, mie_clear_out, mie_set_out,
//          misaligned_exception_out (comb), instret_inc_out.
module msrv32_machine_control
  import msrv32_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic [4:0] opcode_6_to_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs2_addr_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       trap_taken_out,
  output logic       set_epc_out,
  output logic       set_cause_out,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       misaligned_exception_out,
  output logic       instret_inc_out
);

  state_e     state_q, state_d;
  logic       i_or_e_q;
  logic [3:0] cause_q;
  logic       trap_valid, trap_i_or_e, mret;
  logic [3:0] trap_cause;

  msrv32_trap_cause_enc u_cause_enc (
    .illegal_instr_i    (illegal_instr_in),
    .misaligned_instr_i (misaligned_instr_in),
    .misaligned_load_i  (misaligned_load_in),
    .misaligned_store_i (misaligned_store_in),
    .opcode_6_to_2_i    (opcode_6_to_2_in),
    .funct3_i           (funct3_in),
    .funct7_i           (funct7_in),
    .rs2_addr_i         (rs2_addr_in),
    .mie_i              (mie_in),
    .meie_i             (meie_in),
    .mtie_i             (mtie_in),
    .msie_i             (msie_in),
    .meip_i             (meip_in),
    .mtip_i             (mtip_in),
    .msip_i             (msip_in),
    .valid_o            (trap_valid),
    .i_or_e_o           (trap_i_or_e),
    .cause_o            (trap_cause),
    .mret_o             (mret)
  );

  assign misaligned_exception_out = misaligned_instr_in | misaligned_load_in | misaligned_store_in;

  // Traps and mret are only sampled in OPERATING; the 1-cycle states always
  // fall back to OPERATING, so a still-pending irq is re-evaluated there.
  always_comb begin
    state_d = ST_OPERATING;
    if (state_q == ST_OPERATING) begin
      if (trap_valid) state_d = ST_TRAP_TAKEN;
      else if (mret)  state_d = ST_TRAP_RETURN;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= ST_RESET;
      i_or_e_q <= 1'b0;
      cause_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_OPERATING && trap_valid) begin
        i_or_e_q <= trap_i_or_e;
        cause_q  <= trap_cause;
      end
    end
  end

  assign i_or_e_out = i_or_e_q;
  assign cause_out  = cause_q;

  // Moore decode straight from the state register.
  always_comb begin
    pc_src_out      = PC_SRC_BOOT;
    flush_out       = 1'b0;
    trap_taken_out  = 1'b0;
    set_epc_out     = 1'b0;
    set_cause_out   = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    case (state_q)
      ST_OPERATING: begin
        pc_src_out      = PC_SRC_NEXT;
        instret_inc_out = 1'b1;
      end
      ST_TRAP_TAKEN: begin
        pc_src_out     = PC_SRC_TRAP;
        flush_out      = 1'b1;
        trap_taken_out = 1'b1;
        set_epc_out    = 1'b1;
        set_cause_out  = 1'b1;
        mie_clear_out  = 1'b1;
      end
      ST_TRAP_RETURN: begin
        pc_src_out  = PC_SRC_EPC;
        flush_out   = 1'b1;
        mie_set_out = 1'b1;
      end
      default: begin
        pc_src_out = PC_SRC_BOOT;
        flush_out  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_msrv32_machine_control.sv
module tb_msrv32_machine_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       illegal, mis_instr, mis_load, mis_store;
  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs2;
  logic       mie, meie, mtie, msie, meip, mtip, msip;
  logic [1:0] pc_src;
  logic       flush, trap_taken, set_epc, set_cause, i_or_e;
  logic [3:0] cause;
  logic       mie_clear, mie_set, mis_exc, instret_inc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msrv32_machine_control dut (
    .clk_in                   (clk),
    .reset_n_in               (reset_n),
    .illegal_instr_in         (illegal),
    .misaligned_instr_in      (mis_instr),
    .misaligned_load_in       (mis_load),
    .misaligned_store_in      (mis_store),
    .opcode_6_to_2_in         (opcode),
    .funct3_in                (funct3),
    .funct7_in                (funct7),
    .rs2_addr_in              (rs2),
    .mie_in                   (mie),
    .meie_in                  (meie),
    .mtie_in                  (mtie),
    .msie_in                  (msie),
    .meip_in                  (meip),
    .mtip_in                  (mtip),
    .msip_in                  (msip),
    .pc_src_out               (pc_src),
    .flush_out                (flush),
    .trap_taken_out           (trap_taken),
    .set_epc_out              (set_epc),
    .set_cause_out            (set_cause),
    .i_or_e_out               (i_or_e),
    .cause_out                (cause),
    .mie_clear_out            (mie_clear),
    .mie_set_out              (mie_set),
    .misaligned_exception_out (mis_exc),
    .instret_inc_out          (instret_inc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs were driven at a negedge, sampling happens at the next negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    illegal = 0; mis_instr = 0; mis_load = 0; mis_store = 0;
    opcode = '0; funct3 = '0; funct7 = '0; rs2 = '0;
    mie = 0; meie = 0; mtie = 0; msie = 0; meip = 0; mtip = 0; msip = 0;
  endtask

  task automatic set_system(input logic [6:0] f7, input logic [4:0] r2);
    opcode = 5'b11100; funct3 = 3'b000; funct7 = f7; rs2 = r2;
  endtask

  // Expect TRAP_TAKEN outputs with the given cause.
  task automatic chk_trap(input string tag, input logic ie, input logic [3:0] c);
    chk({tag, ".pc_src"}, 32'(pc_src), 32'h2);
    chk({tag, ".flush"}, 32'(flush), 32'h1);
    chk({tag, ".strobes"}, {28'd0, trap_taken, set_epc, set_cause, mie_clear}, 32'hF);
    chk({tag, ".mie_set"}, 32'(mie_set), 32'h0);
    chk({tag, ".instret"}, 32'(instret_inc), 32'h0);
    chk({tag, ".i_or_e"}, 32'(i_or_e), 32'(ie));
    chk({tag, ".cause"}, 32'(cause), 32'(c));
  endtask

  task automatic chk_oper(input string tag);
    chk({tag, ".pc_src"}, 32'(pc_src), 32'h3);
    chk({tag, ".instret"}, 32'(instret_inc), 32'h1);
    chk({tag, ".flush"}, 32'(flush), 32'h0);
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.pc_src", 32'(pc_src), 32'h0);
    chk("rst.flush", 32'(flush), 32'h1);
    chk("rst.cause", {27'd0, i_or_e, cause}, 32'h0);
    chk("rst.instret", 32'(instret_inc), 32'h0);

    // Reset release: first cycle still RESET, next OPERATING.
    reset_n = 1;
    #1;
    chk("rel1.pc_src", 32'(pc_src), 32'h0);
    chk("rel1.flush", 32'(flush), 32'h1);
    step();
    chk_oper("rel2");

    // Illegal instruction -> cause 2, one cycle, back to OPERATING with cause held.
    illegal = 1;
    #1 chk("ill.mis_exc", 32'(mis_exc), 32'h0);
    step();
    illegal = 0;
    chk_trap("ill", 1'b0, 4'd2);
    step();
    chk_oper("ill_back");
    chk("ill_back.cause", 32'(cause), 32'h2);

    // External + timer pending with MIE: external wins. Held irq re-taken only after OPERATING.
    mie = 1; meie = 1; meip = 1; mtie = 1; mtip = 1;
    step();
    chk_trap("ext", 1'b1, 4'd11);
    step();
    chk_oper("ext_gap");
    step();
    chk_trap("ext_again", 1'b1, 4'd11);
    mie = 0;
    step();
    chk_oper("mie0_a");
    step();
    chk_oper("mie0_b");
    meie = 0; meip = 0;

    // Timer only.
    mie = 1;
    step();
    clear_inputs();
    chk_trap("tmr", 1'b1, 4'd7);
    step();

    // ecall together with misaligned load -> load misaligned wins.
    set_system(7'b0000000, 5'b00000);
    mis_load = 1;
    #1 chk("eld.mis_exc", 32'(mis_exc), 32'h1);
    step();
    clear_inputs();
    chk_trap("eld", 1'b0, 4'd4);
    step();

    // Plain ecall -> 11, exception.
    set_system(7'b0000000, 5'b00000);
    step();
    clear_inputs();
    chk_trap("ecall", 1'b0, 4'd11);
    step();

    // ebreak -> 3, exception.
    set_system(7'b0000000, 5'b00001);
    step();
    clear_inputs();
    chk_trap("ebrk", 1'b0, 4'd3);
    step();

    // misaligned_instr beats illegal -> 0.
    mis_instr = 1; illegal = 1;
    step();
    clear_inputs();
    chk_trap("mi", 1'b0, 4'd0);
    step();

    // misaligned store -> 6, and beats a pending interrupt.
    mis_store = 1; mie = 1; msie = 1; msip = 1;
    step();
    clear_inputs();
    chk_trap("mst", 1'b0, 4'd6);
    step();

    // mret -> TRAP_RETURN then OPERATING.
    set_system(7'b0011000, 5'b00010);
    step();
    clear_inputs();
    chk("mret.pc_src", 32'(pc_src), 32'h1);
    chk("mret.flush", 32'(flush), 32'h1);
    chk("mret.mie_set", 32'(mie_set), 32'h1);
    chk("mret.trap", {29'd0, trap_taken, set_cause, mie_clear}, 32'h0);
    chk("mret.cause_held", 32'(cause), 32'h6);
    step();
    chk_oper("mret_back");

    // mret with software interrupt pending -> trap wins.
    set_system(7'b0011000, 5'b00010);
    mie = 1; msie = 1; msip = 1;
    step();
    clear_inputs();
    chk_trap("mret_sw", 1'b1, 4'd3);
    step();
    chk_oper("mret_sw_back");

    // Asynchronous reset in the middle of TRAP_TAKEN.
    illegal = 1;
    step();
    illegal = 0;
    chk_trap("pre_rst", 1'b0, 4'd2);
    #2 reset_n = 0;
    #1;
    chk("arst.pc_src", 32'(pc_src), 32'h0);
    chk("arst.flush", 32'(flush), 32'h1);
    chk("arst.trap", {28'd0, trap_taken, set_epc, set_cause, mie_clear}, 32'h0);
    chk("arst.cause", {27'd0, i_or_e, cause}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
